hx8352_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single `hx8352_controller` write port between up to `N` requesters (e.g. counter readout, text renderer, debug overlay). It grants the LCD to one requester for a whole burst of command/data words, forwards that requester's words under the controller's busy handshake, and enforces fairness with a burst-length cap and an idle timeout. It sits between the requesters and `hx8352_u0` in `system`, clocked from the PLL 1 MHz output.

---
 rtl/hx8352_bus_arbiter_if.sv | 29 ++
 rtl/hx8352_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_hx8352_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hx8352_bus_arbiter_if.sv
// Requester/controller bundle around the HX8352 write-port arbiter.
// The slave modport is the arbiter's view; master is the requesters'/controller's view.
interface hx8352_bus_arbiter_if #(
   parameter int N  = 3,
   parameter int DW = 16
);
   logic [N-1:0]    req;
   logic [N-1:0]    last;
   logic [N-1:0]    rs;
   logic [N*DW-1:0] data_in;
   logic [N-1:0]    ack;
   logic [N-1:0]    gnt;
   logic            abort;
   logic            lcd_valid;
   logic            lcd_rs;
   logic [DW-1:0]   lcd_data;
   logic            lcd_busy;
   logic            lcd_init_done;

   modport slave (
      input  req, last, rs, data_in, lcd_busy, lcd_init_done,
      output ack, gnt, abort, lcd_valid, lcd_rs, lcd_data
   );

   modport master (
      output req, last, rs, data_in, lcd_busy, lcd_init_done,
      input  ack, gnt, abort, lcd_valid, lcd_rs, lcd_data
   );
endinterface

// File: rtl/hx8352_bus_arbiter.sv
// Round-robin arbiter sharing the hx8352_controller write port between N requesters,
// one grant per burst, with a burst-length cap and an idle timeout forcing release.
module hx8352_bus_arbiter #(
   parameter int N            = 3,
   parameter int DW           = 16,
   parameter int MAX_BURST    = 64,
   parameter int IDLE_TIMEOUT = 255
) (
   input logic                 clk_1MHz,
   input logic                 rst,
   hx8352_bus_arbiter_if.slave bus
);
   localparam int PW  = (N > 1) ? $clog2(N) : 1;
   localparam int WCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
   localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
   localparam int DIW = $clog2(N * DW);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [PW-1:0]  ptr, ptr_nx;
   logic [PW-1:0]  g_idx, g_idx_nx;
   logic [N-1:0]   gnt_q, gnt_nx;
   logic [WCW-1:0] word_cnt, word_cnt_nx;
   logic [ICW-1:0] idle_cnt, idle_cnt_nx;
   logic           abort_q, abort_nx;

   logic           found;
   logic [PW-1:0]  sel;
   logic [PW-1:0]  g_next;
   logic [DIW-1:0] base;
   logic           release_g;
   logic [N-1:0]   ack_c;
   logic           valid_c;
   logic           rs_c;
   logic [DW-1:0]  data_c;

   // First requesting index at or after ptr, wrapping modulo N.
   always_comb begin
      logic [PW-1:0] cand;
      cand  = '0;
      found = 1'b0;
      sel   = ptr;
      for (int unsigned i = 0; i < N; i++) begin
         cand = PW'((32'(ptr) + i) % N);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign g_next = (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
   assign base   = DIW'(g_idx) * DIW'(DW);

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      g_idx_nx    = g_idx;
      gnt_nx      = gnt_q;
      word_cnt_nx = word_cnt;
      idle_cnt_nx = idle_cnt;
      abort_nx    = 1'b0;
      release_g   = 1'b0;
      ack_c       = '0;
      valid_c     = 1'b0;
      rs_c        = 1'b0;
      data_c      = '0;
      // Losing init overrides everything: no transfer, no abort, ptr kept.
      if (!bus.lcd_init_done) begin
         state_nx = IDLE;
         gnt_nx   = '0;
      end else begin
         unique case (state)
            IDLE: state_nx = ARB;
            ARB: begin
               if (found) begin
                  gnt_nx      = N'(1) << sel;
                  g_idx_nx    = sel;
                  word_cnt_nx = '0;
                  idle_cnt_nx = '0;
                  state_nx    = GRANT;
               end
            end
            GRANT: begin
               valid_c = bus.req[g_idx];
               rs_c    = bus.rs[g_idx];
               data_c  = bus.data_in[base +: DW];
               if (valid_c && !bus.lcd_busy) begin
                  ack_c       = N'(1) << g_idx;
                  idle_cnt_nx = '0;
                  if (MAX_BURST != 0) word_cnt_nx = word_cnt + 1'b1;
                  if (bus.last[g_idx]) begin
                     release_g = 1'b1;
                  end else if ((MAX_BURST != 0) && (word_cnt == WCW'(MAX_BURST - 1))) begin
                     release_g = 1'b1;
                     abort_nx  = 1'b1;
                  end
               end else if (!valid_c) begin
                  if (idle_cnt == ICW'(IDLE_TIMEOUT - 1)) begin
                     release_g = 1'b1;
                     abort_nx  = 1'b1;
                  end else begin
                     idle_cnt_nx = idle_cnt + 1'b1;
                  end
               end else begin
                  idle_cnt_nx = '0;
               end
               if (release_g) begin
                  state_nx = ARB;
                  gnt_nx   = '0;
                  ptr_nx   = g_next;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_1MHz or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         g_idx    <= '0;
         gnt_q    <= '0;
         word_cnt <= '0;
         idle_cnt <= '0;
         abort_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         g_idx    <= g_idx_nx;
         gnt_q    <= gnt_nx;
         word_cnt <= word_cnt_nx;
         idle_cnt <= idle_cnt_nx;
         abort_q  <= abort_nx;
      end
   end

   assign bus.ack       = ack_c;
   assign bus.gnt       = gnt_q;
   assign bus.abort     = abort_q;
   assign bus.lcd_valid = valid_c;
   assign bus.lcd_rs    = rs_c;
   assign bus.lcd_data  = data_c;
endmodule

// File: tb/tb_hx8352_bus_arbiter.sv
// Scoreboard bench for hx8352_bus_arbiter: stimulus queues expected acks/grants/aborts,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_hx8352_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   hx8352_bus_arbiter_if #(.N(3), .DW(16)) bus ();

   hx8352_bus_arbiter #(.N(3), .DW(16), .MAX_BURST(4), .IDLE_TIMEOUT(5)) dut (
      .clk_1MHz (clk),
      .rst      (rst),
      .bus      (bus)
   );

   always #500 clk = ~clk;

   typedef struct {
      logic        last;
      logic        rs;
      logic [15:0] data;
   } word_t;

   typedef struct {
      int          who;
      logic        rs;
      logic [15:0] data;
   } exp_t;

   word_t      q0[$], q1[$], q2[$];
   exp_t       exp_ack[$];
   logic [2:0] exp_gnt[$];
   logic [2:0] exp_abort[$];
   int         ack_cyc[$];

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         n_acks = 0;
   int         busy_mode = 0;
   logic [2:0] ack_s = '0;
   logic [2:0] gnt_prev = '0;
   logic [2:0] last_gnt = '0;
   logic       abort_prev = 1'b0;
   exp_t       mon_e;
   logic [2:0] mon_oh;
   logic [2:0] mon_g;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic push_word(input int who, input logic l, input logic r, input logic [15:0] d);
      word_t w;
      w.last = l;
      w.rs   = r;
      w.data = d;
      case (who)
         0:       q0.push_back(w);
         1:       q1.push_back(w);
         default: q2.push_back(w);
      endcase
   endtask

   task automatic expect_ack(input int who, input logic r, input logic [15:0] d);
      exp_t e;
      e.who  = who;
      e.rs   = r;
      e.data = d;
      exp_ack.push_back(e);
   endtask

   task automatic drive();
      logic [2:0]  r, l, s;
      logic [47:0] d;
      r = '0; l = '0; s = '0; d = '0;
      if (q0.size() > 0) begin r[0] = 1'b1; l[0] = q0[0].last; s[0] = q0[0].rs; d[15:0]  = q0[0].data; end
      if (q1.size() > 0) begin r[1] = 1'b1; l[1] = q1[0].last; s[1] = q1[0].rs; d[31:16] = q1[0].data; end
      if (q2.size() > 0) begin r[2] = 1'b1; l[2] = q2[0].last; s[2] = q2[0].rs; d[47:32] = q2[0].data; end
      bus.req     = r;
      bus.last    = l;
      bus.rs      = s;
      bus.data_in = d;
   endtask

   // Requester model: hold the head word until its ack was seen, then advance.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst) begin
         if (ack_s[0] && q0.size() > 0) void'(q0.pop_front());
         if (ack_s[1] && q1.size() > 0) void'(q1.pop_front());
         if (ack_s[2] && q2.size() > 0) void'(q2.pop_front());
      end
      ack_s = '0;
      drive();
      bus.lcd_busy = (busy_mode == 1) || ((busy_mode == 2) && ((cyc % 3) != 0));
   end

   always @(negedge clk) begin
      ack_s = bus.ack;
      if (rst) begin
         gnt_prev   = '0;
         abort_prev = 1'b0;
      end else begin
         if (bus.ack != '0) begin
            n_acks++;
            ack_cyc.push_back(cyc);
            if (exp_ack.size() == 0) begin
               chk("unexpected ack", 32'(bus.ack), 32'd0);
            end else begin
               mon_e  = exp_ack.pop_front();
               mon_oh = 3'b001 << mon_e.who;
               chk("ack vector", 32'(bus.ack), 32'(mon_oh));
               chk("ack word", 32'({bus.lcd_rs, bus.lcd_data}), 32'({mon_e.rs, mon_e.data}));
               chk("ack granted idle valid", 32'({bus.ack & ~bus.gnt, bus.lcd_busy, bus.lcd_valid}), 32'd1);
            end
         end
         if (bus.gnt != '0 && gnt_prev == '0) begin
            if (exp_gnt.size() == 0) begin
               chk("unexpected grant", 32'(bus.gnt), 32'd0);
            end else begin
               mon_g = exp_gnt.pop_front();
               chk("grant", 32'(bus.gnt), 32'(mon_g));
            end
         end
         if (bus.abort) begin
            chk("abort single cycle", 32'(abort_prev), 32'd0);
            if (exp_abort.size() == 0) begin
               chk("unexpected abort", 32'(bus.abort), 32'd0);
            end else begin
               mon_g = exp_abort.pop_front();
               chk("abort owner", 32'(last_gnt), 32'(mon_g));
            end
         end
         gnt_prev = bus.gnt;
         if (bus.gnt != '0) last_gnt = bus.gnt;
         abort_prev = bus.abort;
      end
   end

   task automatic start_test();
      rst = 1'b1;
      bus.lcd_init_done = 1'b1;
      busy_mode = 0;
      q0.delete(); q1.delete(); q2.delete();
      exp_ack.delete(); exp_gnt.delete(); exp_abort.delete(); ack_cyc.delete();
      n_acks = 0;
      @(posedge clk);
      #3;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_ack.size() != 0 || exp_gnt.size() != 0 || exp_abort.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, " drained"}, 32'(exp_ack.size() + exp_gnt.size() + exp_abort.size()), 32'd0);
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_acks(input int target, input int budget);
      int n = 0;
      while (n_acks < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("ack wait", 32'(n_acks >= target), 32'd1);
   endtask

   initial begin
      bus.lcd_init_done = 1'b1;
      bus.lcd_busy = 1'b0;
      drive();

      // Async reset in the middle of a stalled grant with all requesters active.
      start_test();
      busy_mode = 1;
      push_word(0, 1'b1, 1'b1, 16'h1111);
      push_word(1, 1'b1, 1'b0, 16'h2222);
      push_word(2, 1'b1, 1'b1, 16'h3333);
      exp_gnt.push_back(3'b001); exp_gnt.push_back(3'b001);
      exp_gnt.push_back(3'b010); exp_gnt.push_back(3'b100);
      expect_ack(0, 1'b1, 16'h1111);
      expect_ack(1, 1'b0, 16'h2222);
      expect_ack(2, 1'b1, 16'h3333);
      release_rst();
      repeat (5) @(negedge clk);
      chk("stalled grant", 32'({bus.gnt, bus.req, bus.lcd_valid, bus.lcd_data}), 32'({3'b001, 3'b111, 1'b1, 16'h1111}));
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("async reset outputs",
             32'({bus.gnt, bus.ack, bus.abort, bus.lcd_valid, bus.lcd_rs, bus.lcd_data}), 32'd0);
      repeat (2) @(negedge clk);
      busy_mode = 0;
      rst = 1'b0;
      wait_drain("reset", 60);

      // Round robin with single-word bursts.
      start_test();
      push_word(0, 1'b1, 1'b0, 16'hA000);
      push_word(0, 1'b1, 1'b1, 16'hA001);
      push_word(1, 1'b1, 1'b1, 16'hB000);
      push_word(2, 1'b1, 1'b0, 16'hC000);
      exp_gnt.push_back(3'b001); exp_gnt.push_back(3'b010);
      exp_gnt.push_back(3'b100); exp_gnt.push_back(3'b001);
      expect_ack(0, 1'b0, 16'hA000);
      expect_ack(1, 1'b1, 16'hB000);
      expect_ack(2, 1'b0, 16'hC000);
      expect_ack(0, 1'b1, 16'hA001);
      release_rst();
      wait_drain("round robin", 60);
      chk("rr ack count", 32'(ack_cyc.size()), 32'd4);
      for (int i = 1; i < ack_cyc.size(); i++)
         chk("rr ack spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);

      // Busy handshake: busy high two of every three cycles.
      start_test();
      busy_mode = 2;
      push_word(1, 1'b0, 1'b1, 16'hB001);
      push_word(1, 1'b0, 1'b0, 16'hB002);
      push_word(1, 1'b1, 1'b1, 16'hB003);
      exp_gnt.push_back(3'b010);
      expect_ack(1, 1'b1, 16'hB001);
      expect_ack(1, 1'b0, 16'hB002);
      expect_ack(1, 1'b1, 16'hB003);
      release_rst();
      wait_drain("busy", 60);
      chk("busy ack count", 32'(n_acks), 32'd3);

      // Burst cap of 4 with requester 2 waiting; tail ends in idle timeout.
      start_test();
      for (int k = 0; k < 10; k++)
         push_word(0, 1'b0, ((k % 2) == 1), 16'h0100 + 16'(k));
      push_word(2, 1'b1, 1'b1, 16'h2AAA);
      exp_gnt.push_back(3'b001); exp_gnt.push_back(3'b100);
      exp_gnt.push_back(3'b001); exp_gnt.push_back(3'b001);
      for (int k = 0; k < 4; k++) expect_ack(0, ((k % 2) == 1), 16'h0100 + 16'(k));
      expect_ack(2, 1'b1, 16'h2AAA);
      for (int k = 4; k < 10; k++) expect_ack(0, ((k % 2) == 1), 16'h0100 + 16'(k));
      exp_abort.push_back(3'b001); exp_abort.push_back(3'b001); exp_abort.push_back(3'b001);
      release_rst();
      wait_drain("burst cap", 120);

      // Idle timeout: a 4-cycle stall keeps the grant, 5 idle cycles revoke it.
      start_test();
      push_word(0, 1'b0, 1'b0, 16'hC001);
      exp_gnt.push_back(3'b001);
      expect_ack(0, 1'b0, 16'hC001);
      expect_ack(0, 1'b1, 16'hC002);
      exp_abort.push_back(3'b001);
      release_rst();
      wait_acks(1, 40);
      repeat (3) @(posedge clk);
      #3 push_word(0, 1'b0, 1'b1, 16'hC002);
      @(posedge clk);
      #3 chk("stall 4 keeps grant", 32'({bus.gnt, bus.abort}), 32'({3'b001, 1'b0}));
      wait_acks(2, 10);
      repeat (4) @(posedge clk);
      #3 chk("idle 4 keeps grant", 32'({bus.gnt, bus.abort}), 32'({3'b001, 1'b0}));
      @(posedge clk);
      #3 chk("timeout release", 32'({bus.gnt, bus.abort}), 32'({3'b000, 1'b1}));
      wait_drain("idle timeout", 30);

      // Init loss mid-burst, then resume from the saved pointer.
      start_test();
      push_word(0, 1'b1, 1'b0, 16'h5A00);
      push_word(0, 1'b1, 1'b0, 16'h5A01);
      push_word(1, 1'b0, 1'b1, 16'h5B00);
      push_word(1, 1'b0, 1'b1, 16'h5B01);
      push_word(1, 1'b1, 1'b1, 16'h5B02);
      push_word(2, 1'b1, 1'b0, 16'h5C00);
      exp_gnt.push_back(3'b001); exp_gnt.push_back(3'b010); exp_gnt.push_back(3'b010);
      exp_gnt.push_back(3'b100); exp_gnt.push_back(3'b001);
      expect_ack(0, 1'b0, 16'h5A00);
      expect_ack(1, 1'b1, 16'h5B00);
      expect_ack(1, 1'b1, 16'h5B01);
      expect_ack(1, 1'b1, 16'h5B02);
      expect_ack(2, 1'b0, 16'h5C00);
      expect_ack(0, 1'b0, 16'h5A01);
      release_rst();
      wait_acks(3, 40);
      #2 bus.lcd_init_done = 1'b0;
      @(negedge clk);
      chk("init loss no ack", 32'({bus.ack, bus.gnt}), 32'({3'b000, 3'b010}));
      @(negedge clk);
      chk("init loss idle", 32'({bus.gnt, bus.abort, bus.lcd_valid}), 32'd0);
      repeat (3) @(posedge clk);
      #2 bus.lcd_init_done = 1'b1;
      wait_drain("init loss", 60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #(1000 * 20000);
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
